// File: rtl/bip_loader_ctrl.sv
// bip_loader_ctrl: host-side sequencer for the BIP core. Packs UART bytes
// into program memory words, releases the CPU until HALT or watchdog, and
// streams data memory back out over the UART transmitter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a command byte (0x01 LOAD, 0x02 RUN, 0x03 DUMP)
// LD_NLO   | LOAD: receive word count, low byte
// LD_NHI   | LOAD: receive word count, high byte
// LD_LO    | LOAD: receive data word, low byte
// LD_HI    | LOAD: receive data word, high byte
// LD_WR    | LOAD: one-cycle program memory write
// LD_ACK   | LOAD: transmit 0x55
// RUN      | CPU out of reset, watching for HALT or watchdog expiry
// RUN_ACK  | transmit 0xAA (HALT) or 0xEE (watchdog)
// DP_NLO   | DUMP: receive word count, low byte
// DP_NHI   | DUMP: receive word count, high byte
// DP_RD    | DUMP: one-cycle data memory read strobe
// DP_WAIT  | DUMP: capture read data (1-cycle memory latency)
// DP_TXL   | DUMP: transmit bits [7:0] of the captured word
// DP_TXH   | DUMP: transmit bits [15:8] of the captured word
module bip_loader_ctrl #(
    parameter int         DATA_LENGTH = 16,
    parameter int         ADDR_LENGTH = 11,
    parameter logic [4:0] HALT_OPCODE = 5'b00000,
    parameter int         WDOG_BITS   = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_done,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_done,
    input  logic [DATA_LENGTH-1:0] instr_from_pm,
    input  logic [DATA_LENGTH-1:0] data_from_dm,
    output logic                   WrPM,
    output logic                   WrDM,
    output logic                   RdDM,
    output logic [DATA_LENGTH-1:0] dataFromInterface,
    output logic [ADDR_LENGTH-1:0] addrFromInterface,
    output logic                   reset_bip,
    output logic [3:0]             state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LD_NLO  = 4'd1,
        S_LD_NHI  = 4'd2,
        S_LD_LO   = 4'd3,
        S_LD_HI   = 4'd4,
        S_LD_WR   = 4'd5,
        S_LD_ACK  = 4'd6,
        S_RUN     = 4'd7,
        S_RUN_ACK = 4'd8,
        S_DP_NLO  = 4'd9,
        S_DP_NHI  = 4'd10,
        S_DP_RD   = 4'd11,
        S_DP_WAIT = 4'd12,
        S_DP_TXL  = 4'd13,
        S_DP_TXH  = 4'd14
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_DUMP = 8'h03;
    localparam logic [7:0] ACK_LOAD = 8'h55;
    localparam logic [7:0] ACK_HALT = 8'hAA;
    localparam logic [7:0] ACK_WDOG = 8'hEE;

    state_t                 state;
    state_t                 state_nxt;
    logic [15:0]            cnt;
    logic [ADDR_LENGTH-1:0] addr;
    logic [DATA_LENGTH-1:0] word;
    logic [WDOG_BITS-1:0]   wdog;
    logic [WDOG_BITS-1:0]   wdog_inc;
    logic                   halt_seen;
    logic                   wdog_tc;
    logic                   cnt_last;
    logic                   n_zero;
    logic                   tx_load;
    logic [7:0]             tx_byte_nxt;
    logic                   instr_unused;

    // Watchdog holds RUN-cycle-minus-one, so a nonzero value means the
    // CPU has had at least one cycle to leave reset before HALT is trusted.
    assign wdog_inc     = wdog + WDOG_BITS'(1);
    assign wdog_tc      = &wdog_inc;
    assign halt_seen    = (wdog != '0) && (instr_from_pm[DATA_LENGTH-1 -: 5] == HALT_OPCODE);
    assign cnt_last     = (cnt == 16'd1);
    assign n_zero       = ({rx_data, cnt[7:0]} == 16'd0);
    assign instr_unused = ^instr_from_pm[DATA_LENGTH-6:0];

    assign WrDM              = 1'b0;
    assign addrFromInterface = addr;
    assign state_dbg         = state;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rx_done) begin
                    case (rx_data)
                        CMD_LOAD: state_nxt = S_LD_NLO;
                        CMD_RUN:  state_nxt = S_RUN;
                        CMD_DUMP: state_nxt = S_DP_NLO;
                        default:  state_nxt = S_IDLE;
                    endcase
                end
            end
            S_LD_NLO:  if (rx_done) state_nxt = S_LD_NHI;
            S_LD_NHI:  if (rx_done) state_nxt = n_zero ? S_LD_ACK : S_LD_LO;
            S_LD_LO:   if (rx_done) state_nxt = S_LD_HI;
            S_LD_HI:   if (rx_done) state_nxt = S_LD_WR;
            S_LD_WR:   state_nxt = cnt_last ? S_LD_ACK : S_LD_LO;
            S_LD_ACK:  if (tx_done) state_nxt = S_IDLE;
            S_RUN:     if (halt_seen || wdog_tc) state_nxt = S_RUN_ACK;
            S_RUN_ACK: if (tx_done) state_nxt = S_IDLE;
            S_DP_NLO:  if (rx_done) state_nxt = S_DP_NHI;
            S_DP_NHI:  if (rx_done) state_nxt = n_zero ? S_IDLE : S_DP_RD;
            S_DP_RD:   state_nxt = S_DP_WAIT;
            S_DP_WAIT: state_nxt = S_DP_TXL;
            S_DP_TXL:  if (tx_done) state_nxt = S_DP_TXH;
            S_DP_TXH:  if (tx_done) state_nxt = cnt_last ? S_IDLE : S_DP_RD;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Byte to launch when a transmit state is entered; the DP_TXL byte is
    // taken straight from the memory bus since word captures it on the same edge.
    always_comb begin
        tx_load     = 1'b0;
        tx_byte_nxt = tx_data;
        if (state_nxt != state) begin
            case (state_nxt)
                S_LD_ACK: begin
                    tx_load     = 1'b1;
                    tx_byte_nxt = ACK_LOAD;
                end
                S_RUN_ACK: begin
                    tx_load     = 1'b1;
                    tx_byte_nxt = halt_seen ? ACK_HALT : ACK_WDOG;
                end
                S_DP_TXL: begin
                    tx_load     = 1'b1;
                    tx_byte_nxt = data_from_dm[7:0];
                end
                S_DP_TXH: begin
                    tx_load     = 1'b1;
                    tx_byte_nxt = word[15:8];
                end
                default: begin
                    tx_load     = 1'b0;
                    tx_byte_nxt = tx_data;
                end
            endcase
        end
    end

    // Count, address, word assembly and watchdog
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt               <= '0;
            addr              <= '0;
            word              <= '0;
            wdog              <= '0;
            dataFromInterface <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_done && (rx_data == CMD_LOAD || rx_data == CMD_DUMP)) begin
                        addr <= '0;
                    end
                end
                S_LD_NLO, S_DP_NLO: if (rx_done) cnt[7:0] <= rx_data;
                S_LD_NHI, S_DP_NHI: if (rx_done) cnt[15:8] <= rx_data;
                S_LD_LO:            if (rx_done) word[7:0] <= rx_data;
                S_LD_HI: begin
                    if (rx_done) begin
                        dataFromInterface <= DATA_LENGTH'({rx_data, word[7:0]});
                    end
                end
                S_LD_WR: begin
                    cnt  <= cnt - 16'd1;
                    addr <= addr + ADDR_LENGTH'(1);
                end
                S_DP_WAIT: begin
                    word <= data_from_dm;
                    addr <= addr + ADDR_LENGTH'(1);
                end
                S_DP_TXH: if (tx_done) cnt <= cnt - 16'd1;
                default: ;
            endcase

            if (state != S_RUN && state_nxt == S_RUN) begin
                wdog <= '0;
            end else if (state == S_RUN) begin
                wdog <= wdog_inc;
            end
        end
    end

    // Registered strobes, transmit launch and CPU reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            WrPM      <= 1'b0;
            RdDM      <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            reset_bip <= 1'b1;
        end else begin
            WrPM      <= (state_nxt == S_LD_WR);
            RdDM      <= (state_nxt == S_DP_RD);
            tx_start  <= tx_load;
            if (tx_load) begin
                tx_data <= tx_byte_nxt;
            end
            reset_bip <= (state != S_RUN);
        end
    end

endmodule

// File: tb/tb_bip_loader_ctrl.sv
// Bench for bip_loader_ctrl: models program memory with a trivial CPU fetch,
// data memory with 1-cycle read latency, and a UART transmitter responder.
module tb_bip_loader_ctrl;

    localparam int DL  = 16;
    localparam int AL  = 11;
    localparam int WB  = 6;
    localparam int LIM = (1 << WB) - 1;

    logic          clk;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_done;
    logic [DL-1:0] instr_from_pm;
    logic [DL-1:0] data_from_dm;
    logic          WrPM;
    logic          WrDM;
    logic          RdDM;
    logic [DL-1:0] dataFromInterface;
    logic [AL-1:0] addrFromInterface;
    logic          reset_bip;
    logic [3:0]    state_dbg;

    bip_loader_ctrl #(
        .DATA_LENGTH(DL),
        .ADDR_LENGTH(AL),
        .HALT_OPCODE(5'b00000),
        .WDOG_BITS(WB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_done(tx_done),
        .instr_from_pm(instr_from_pm),
        .data_from_dm(data_from_dm),
        .WrPM(WrPM),
        .WrDM(WrDM),
        .RdDM(RdDM),
        .dataFromInterface(dataFromInterface),
        .addrFromInterface(addrFromInterface),
        .reset_bip(reset_bip),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment models ----------------
    logic [15:0] pm [0:2047];
    logic [15:0] dm [0:2047];
    logic        mem_ready = 1'b0;
    logic [10:0] pc;
    logic [15:0] dm_q = 16'h0000;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 2048; i++) begin
                pm[i] <= 16'h0800;
                dm[i] <= 16'(i);
            end
            dm[0]     <= 16'hBEEF;
            dm[1]     <= 16'h0102;
            mem_ready <= 1'b1;
        end else if (WrPM) begin
            pm[addrFromInterface] <= dataFromInterface;
        end
    end

    always @(posedge clk) begin
        pc <= reset_bip ? 11'd0 : pc + 11'd1;
        if (RdDM) dm_q <= dm[addrFromInterface];
    end
    assign instr_from_pm = pm[pc];
    assign data_from_dm  = dm_q;

    logic       tx_busy;
    logic [2:0] tx_cnt;
    logic [7:0] tx_latched;
    always @(posedge clk) begin
        if (!reset) begin
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_cnt     <= 3'd0;
            tx_latched <= 8'h00;
        end else begin
            tx_done <= 1'b0;
            if (tx_busy) begin
                if (tx_cnt == 3'd0) begin
                    tx_done <= 1'b1;
                    tx_busy <= 1'b0;
                end else begin
                    tx_cnt <= tx_cnt - 3'd1;
                end
            end else if (tx_start) begin
                tx_busy    <= 1'b1;
                tx_cnt     <= 3'd3;
                tx_latched <= tx_data;
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [10:0] exp_addr [$];
    logic [15:0] exp_data [$];
    logic [7:0]  exp_tx   [$];
    logic [7:0]  tx_log   [$];
    logic [15:0] ld_words [$];
    logic [15:0] pm_ref   [0:2047];
    int          wr_count  = 0;
    int          rd_count  = 0;
    int          low_cnt   = 0;
    int          low_total = 0;
    int          last_low  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] dm_ref(input int a);
        if (a == 0) return 16'hBEEF;
        if (a == 1) return 16'h0102;
        return 16'(a);
    endfunction

    // CPU fetch model: PC is 0 until reset_bip has been low one edge, so RUN
    // cycle j (j>=2) fetches address j-2. HALT wins a tie with the watchdog.
    task automatic run_model(output int len, output logic [7:0] ack);
        len = LIM;
        ack = 8'hEE;
        for (int a = 0; a + 2 <= LIM; a++) begin
            if (ack != 8'hAA && pm_ref[a][15:11] == 5'b00000) begin
                len = a + 2;
                ack = 8'hAA;
            end
        end
    endtask

    // Compare process: every cycle out of reset
    always @(negedge clk) begin
        if (reset && mem_ready) begin
            chk("wrdm_zero", WrDM, 0);
            chk("wr_rd_excl", WrPM & RdDM, 0);
            chk("no_mem_in_run", (!reset_bip) & (WrPM | RdDM), 0);
            if (WrPM) begin
                wr_count++;
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wrpm actual addr=%0h data=%0h required=no write",
                             addrFromInterface, dataFromInterface);
                end else begin
                    chk("wr_addr", addrFromInterface, exp_addr.pop_front());
                    chk("wr_data", dataFromInterface, exp_data.pop_front());
                end
            end
            if (RdDM) rd_count++;
            if (tx_start) begin
                tx_log.push_back(tx_data);
                chk("tx_after_done", tx_busy, 0);
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx_start actual byte=%0h required=no start", tx_data);
                end else begin
                    chk("tx_byte", tx_data, exp_tx.pop_front());
                end
            end
            if (tx_busy) chk("tx_hold", tx_data, tx_latched);
            if (!reset_bip) begin
                low_cnt++;
                low_total++;
            end else if (low_cnt != 0) begin
                last_low = low_cnt;
                low_cnt  = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        repeat (3) @(posedge clk);
        #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(exp_tx.size() == 0 && !tx_busy && !tx_done && state_dbg == 4'd0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < budget) ? 1 : 0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tx_data"},  tx_data, 0);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_wrpm"},     WrPM, 0);
        chk({tag, "_wrdm"},     WrDM, 0);
        chk({tag, "_rddm"},     RdDM, 0);
        chk({tag, "_data"},     dataFromInterface, 0);
        chk({tag, "_addr"},     addrFromInterface, 0);
        chk({tag, "_reset_bip"}, reset_bip, 1);
        chk({tag, "_state"},    state_dbg, 0);
    endtask

    task automatic do_load(input logic [15:0] n);
        logic [15:0] w;
        exp_tx.push_back(8'h55);
        send_byte(8'h01);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < int'(n); i++) begin
            w = ld_words[i];
            exp_addr.push_back(11'(i));
            exp_data.push_back(w);
            pm_ref[i % 2048] = w;
            send_byte(w[7:0]);
            send_byte(w[15:8]);
            @(negedge clk);
            chk("wrpm_timing", WrPM, 1);
        end
        wait_done("load_done", 400);
        chk("load_writes_done", exp_addr.size(), 0);
    endtask

    task automatic do_run(input string tag);
        int         len;
        logic [7:0] ack;
        run_model(len, ack);
        exp_tx.push_back(ack);
        last_low = 0;
        send_byte(8'h02);
        wait_done({tag, "_done"}, 400);
        chk({tag, "_low_len_model"}, last_low, len);
        chk({tag, "_reset_bip_back"}, reset_bip, 1);
    endtask

    task automatic do_dump(input logic [15:0] n);
        logic [15:0] w;
        int          rd_before;
        rd_before = rd_count;
        for (int i = 0; i < int'(n); i++) begin
            w = dm_ref(i % 2048);
            exp_tx.push_back(w[7:0]);
            exp_tx.push_back(w[15:8]);
        end
        send_byte(8'h03);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        wait_done("dump_done", 400);
        chk("dump_reads", rd_count - rd_before, int'(n));
    endtask

    initial begin
        int base;
        int wr_before;
        int low_before;
        reset   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        for (int i = 0; i < 2048; i++) pm_ref[i] = 16'h0800;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // LOAD N=3
        low_before = low_total;
        ld_words   = {16'h1234, 16'hABCD, 16'h0001};
        do_load(16'd3);
        chk("load_pm0", pm[0], 16'h1234);
        chk("load_pm2", pm[2], 16'h0001);
        chk("load_no_cpu_release", low_total - low_before, 0);

        // LOAD N=0
        wr_before = wr_count;
        do_load(16'd0);
        chk("n0_no_write", wr_count - wr_before, 0);

        // Unknown command byte stays in IDLE
        send_byte(8'h7F);
        @(negedge clk);
        chk("garbage_idle", state_dbg, 0);

        // RUN with HALT at address 4
        ld_words = {16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0000};
        do_load(16'd5);
        base = tx_log.size();
        do_run("halt");
        chk("halt_low_len", last_low, 6);
        chk("halt_ack", tx_log[base], 8'hAA);

        // RUN with no HALT: watchdog
        ld_words = {16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800};
        do_load(16'd5);
        base = tx_log.size();
        do_run("wdog");
        chk("wdog_low_len", last_low, 63);
        chk("wdog_ack", tx_log[base], 8'hEE);

        // DUMP N=2
        base = tx_log.size();
        do_dump(16'd2);
        chk("dump_b0", tx_log[base],     8'hEF);
        chk("dump_b1", tx_log[base + 1], 8'hBE);
        chk("dump_b2", tx_log[base + 2], 8'h02);
        chk("dump_b3", tx_log[base + 3], 8'h01);

        // Reset after the 2nd data byte of a LOAD
        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("pre_reset_wrpm", WrPM, 1);
        chk("pre_reset_data", dataFromInterface, 16'h2211);
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("midrst_pm0_kept", pm[0], 16'h0800);
        base = tx_log.size();
        do_dump(16'd1);
        chk("post_rst_dump_b0", tx_log[base],     8'hEF);
        chk("post_rst_dump_b1", tx_log[base + 1], 8'hBE);

        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("wr_queue_empty", exp_addr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
